// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencing arbiter: ALU opcodes and controller states.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ADD     = 2'b00,
      PASS1   = 2'b01,
      PASS2   = 2'b10,
      ILLEGAL = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SETTLE  = 2'b01,
      RESPOND = 2'b10
   } state_e;

endpackage

// File: rtl/alu_seq_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances only on an accepted grant.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   // Index of the most recently accepted requester; reset value makes requester 0 win first.
   logic last_id;

   always_ff @(posedge clock) begin
      if (!reset) begin
         last_id <= 1'b1;
      end else if (accept) begin
         last_id <= grant[1];
      end
   end

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_id ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_seq_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept, settle wait,
// then a held response until rsp_ready.
module alu_seq_arbiter
   import alu_seq_pkg::*;
#(
   parameter int ADD_WAIT  = 3,
   parameter int PASS_WAIT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [1:0]  alu_opcode,
   output logic [7:0]  alu_i1,
   output logic [7:0]  alu_i2,
   input  logic [7:0]  alu_o1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshakes: a request transfers on the edge where req_valid[n] & req_ready[n];
   // a response transfers on the edge where rsp_valid & rsp_ready. Both sides hold until then.

   if (ADD_WAIT < 1 || ADD_WAIT > 15 || PASS_WAIT < 1 || PASS_WAIT > 15) begin : g_bad_wait
      $error("alu_seq_arbiter: ADD_WAIT and PASS_WAIT must be within 1..15");
   end

   localparam logic [3:0] ADD_LOAD  = 4'(ADD_WAIT - 1);
   localparam logic [3:0] PASS_LOAD = 4'(PASS_WAIT - 1);

   state_e      state, state_nxt;
   logic [3:0]  cnt;
   logic [1:0]  grant;
   logic        accept;
   logic        acc_id;
   logic [1:0]  acc_op;
   logic [7:0]  acc_a, acc_b;

   rr_arb2 u_rr (
      .clock  (clock),
      .reset  (reset),
      .req    (req_valid),
      .accept (accept),
      .grant  (grant)
   );

   assign accept = |(req_valid & req_ready);
   assign acc_id = grant[1];
   assign acc_op = acc_id ? req_op[3:2]  : req_op[1:0];
   assign acc_a  = acc_id ? req_a[15:8]  : req_a[7:0];
   assign acc_b  = acc_id ? req_b[15:8]  : req_b[7:0];

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (acc_op == ILLEGAL) ? RESPOND : SETTLE;
         SETTLE:  if (cnt == 4'd0) state_nxt = RESPOND;
         RESPOND: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE) ? grant : 2'b00;
      busy      = (state != IDLE);
      dbg_state = state;
   end

   // The counter holds remaining SETTLE cycles minus one, so SETTLE lasts exactly WAIT cycles.
   always_ff @(posedge clock) begin
      if (!reset) begin
         alu_opcode <= 2'b00;
         alu_i1     <= 8'h00;
         alu_i2     <= 8'h00;
         rsp_id     <= 1'b0;
         rsp_data   <= 8'h00;
         rsp_err    <= 1'b0;
         rsp_valid  <= 1'b0;
         cnt        <= 4'd0;
      end else begin
         if (accept) begin
            alu_opcode <= acc_op;
            alu_i1     <= acc_a;
            alu_i2     <= acc_b;
            rsp_id     <= acc_id;
            if (acc_op == ILLEGAL) begin
               cnt       <= 4'd0;
               rsp_data  <= 8'h00;
               rsp_err   <= 1'b1;
               rsp_valid <= 1'b1;
            end else begin
               cnt <= (acc_op == ADD) ? ADD_LOAD : PASS_LOAD;
            end
         end
         if (state == SETTLE) begin
            if (cnt == 4'd0) begin
               rsp_data  <= alu_o1;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
         if (state == RESPOND && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
